btn_event: RTL and testbench
============================

// Module: btn_event
// PURPOSE
//  Consumes the synchronised button level from the front-end debouncer and turns it into
//  single-cycle events for control logic: press, release, long-press and (optionally) auto-repeat.
//  Adds an integrating stability filter so residual bounce that survives synchronisation is rejected.
//  Sits between each debouncer instance and the top-level control FSMs; one instance per button.
// PARAMETERS
//  STABLE_CYC  500_000     consecutive equal samples required to accept a press or release (>=1)
//  LONG_CYC    50_000_000  HELD-state cycles before long_pulse (>=1)
//  REPEAT_CYC  10_000_000  HELD-state cycles between repeat_pulse after long-press (>=1)
//  CNT_W       26          width of all counters; must hold max(STABLE_CYC, LONG_CYC, REPEAT_CYC)
// PORTS
//  clk            in   1  system clock; all logic on rising edge
//  rst_n          in   1  asynchronous active-low reset
//  btn_lvl        in   1  synchronised button level, 1 = pressed, synchronous to clk
//  press_pulse    out  1  one-cycle pulse on accepted press
//  release_pulse  out  1  one-cycle pulse on accepted release
//  long_pulse     out  1  one-cycle pulse when hold reaches LONG_CYC
//  repeat_pulse   out  1  one-cycle pulse every REPEAT_CYC after long-press (macro-gated)
//  held           out  1  level: button accepted as pressed (states HELD, REL)
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, all counters 0, every output 0, effective immediately.
//  - FSM states: IDLE, ARM, HELD, REL. stab_cnt used in ARM/REL, hold_cnt in HELD.
//  - IDLE: btn_lvl=1 sampled -> ARM, stab_cnt=1. (If STABLE_CYC=1, go straight to HELD w/ press_pulse.)
//  - ARM: btn_lvl=0 -> IDLE, stab_cnt=0, no event. btn_lvl=1 -> stab_cnt+1; at the edge where the
//    STABLE_CYC-th consecutive 1 is sampled -> HELD, press_pulse=1 and held=1 for the following cycle,
//    hold_cnt=0, rpt_cnt=0.
//  - HELD: btn_lvl=1 -> hold_cnt+1, saturating at LONG_CYC. At the edge hold_cnt becomes LONG_CYC,
//    long_pulse=1 for one cycle (exactly once per press). btn_lvl=0 -> REL, stab_cnt=1.
//  - REL: btn_lvl=1 -> back to HELD, stab_cnt=0, hold_cnt/rpt_cnt frozen (resume, no new press).
//    btn_lvl=0 -> stab_cnt+1; at STABLE_CYC-th consecutive 0 -> IDLE, release_pulse=1, held=0.
//  - hold_cnt and rpt_cnt do not advance in REL or ARM.
//  - Pulses never overlap a reset; at most one of press/release asserted in any cycle.
//  - Reset mid-press (HELD/REL): held drops at once, no release_pulse; if btn_lvl still 1 after
//    reset deassert, a fresh press is accepted after STABLE_CYC samples.
//  - Counter widths: compare with full CNT_W; no wrap permitted on stab_cnt/hold_cnt.
// CONFIGURATION
//  BTN_REPEAT_EN defined: in HELD with hold_cnt saturated at LONG_CYC, rpt_cnt increments each HELD
//    edge; when rpt_cnt reaches REPEAT_CYC, repeat_pulse=1 for one cycle and rpt_cnt reloads to 0
//    (first repeat REPEAT_CYC cycles after long_pulse, then periodic). Frozen in REL.
//  BTN_REPEAT_EN undefined: rpt_cnt not instantiated; repeat_pulse port present, tied 0.
// TESTING (bench params STABLE_CYC=4, LONG_CYC=20, REPEAT_CYC=8)
//  1 rst_n=0 with btn_lvl=1 -> all outputs 0; deassert -> press_pulse 1 cycle after 4th sampled 1.
//  2 btn_lvl=1 for 3 cycles then 0 for 10 -> no pulses, held stays 0.
//  3 btn_lvl=1 x10 then 0 x10 -> exactly one press_pulse, one release_pulse, held high in between,
//    no long_pulse.
//  4 in HELD, btn_lvl=0 x2 then 1 -> no release_pulse, held stays 1, hold_cnt resumes from frozen value.
//  5 btn_lvl=1 x44 with BTN_REPEAT_EN -> press at edge 4, long_pulse at 20 HELD edges, repeat_pulse
//    after 8 and 16 further HELD edges; without macro repeat_pulse constantly 0.
//  6 rst_n=0 asserted mid-HELD -> held and all pulses 0 immediately, no release_pulse after deassert.

Source files
------------

// File: rtl/btn_event.sv
// Button event generator: integrating stability filter plus press/release/long/repeat pulses.
// Optional auto-repeat is compiled in when BTN_REPEAT_EN is defined.
module btn_event #(
    parameter int unsigned STABLE_CYC = 500_000,
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_lvl,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    if (STABLE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1 || CNT_W < 1) begin : g_bad_param
        $error("btn_event: cycle parameters must be >= 1");
    end

    localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] LONG_V   = CNT_W'(LONG_CYC);

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    logic [CNT_W-1:0] stab_inc;
    logic             stab_done;
    logic             hold_sat;

    // stab_q is zero in IDLE and HELD, so the same "done" test covers STABLE_CYC=1 there.
    assign stab_inc  = stab_q + 1'b1;
    assign stab_done = (stab_inc == STABLE_V);
    assign hold_sat  = (hold_q == LONG_V);

    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_lvl) begin
                    if (stab_done) begin
                        state_d = HELD;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        state_d = ARM;
                        stab_d  = stab_inc;
                    end
                end
            end
            ARM: begin
                if (!btn_lvl) begin
                    state_d = IDLE;
                    stab_d  = '0;
                end else if (stab_done) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    stab_d  = '0;
                    hold_d  = '0;
                end else begin
                    stab_d = stab_inc;
                end
            end
            HELD: begin
                if (btn_lvl) begin
                    if (!hold_sat) begin
                        hold_d = hold_q + 1'b1;
                        long_d = ((hold_q + 1'b1) == LONG_V);
                    end
                end else if (stab_done) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    state_d = REL;
                    stab_d  = stab_inc;
                end
            end
            REL: begin
                if (btn_lvl) begin
                    state_d = HELD;
                    stab_d  = '0;
                end else if (stab_done) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    stab_d    = '0;
                end else begin
                    stab_d = stab_inc;
                end
            end
            default: begin
                state_d = IDLE;
                stab_d  = '0;
                hold_d  = '0;
            end
        endcase
        held_d = (state_d == HELD) || (state_d == REL);
    end

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_V = CNT_W'(REPEAT_CYC);

    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic [CNT_W-1:0] rpt_inc;

    assign rpt_inc = rpt_q + 1'b1;

    // Repeat counting only starts on HELD edges after hold_cnt has already saturated.
    always_comb begin
        rpt_d    = rpt_q;
        repeat_d = 1'b0;
        if (press_d) begin
            rpt_d = '0;
        end else if (state_q == HELD && btn_lvl && hold_sat) begin
            if (rpt_inc == REPEAT_V) begin
                rpt_d    = '0;
                repeat_d = 1'b1;
            end else begin
                rpt_d = rpt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign repeat_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stab_q    <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule

// File: tb/tb_btn_event.sv
// Directed-vector bench for btn_event with STABLE_CYC=4, LONG_CYC=20, REPEAT_CYC=8.
// Expected outputs per edge are hand-computed; repeat expectations follow BTN_REPEAT_EN.
module tb_btn_event;

    logic clk;
    logic rst_n;
    logic btn_lvl;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    btn_event #(
        .STABLE_CYC (4),
        .LONG_CYC   (20),
        .REPEAT_CYC (8),
        .CNT_W      (26)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_lvl       (btn_lvl),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bit order: {press, release, long, repeat, held}
    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_HELD  = 5'b00001;
    localparam logic [4:0] E_PRESS = 5'b10001;
    localparam logic [4:0] E_REL   = 5'b01000;
    localparam logic [4:0] E_LONG  = 5'b00101;
`ifdef BTN_REPEAT_EN
    localparam logic [4:0] E_RPT   = 5'b00011;
`else
    localparam logic [4:0] E_RPT   = 5'b00001;
`endif

    typedef struct {
        int         tid;
        logic       rst_n;
        logic       btn;
        logic [4:0] exp;
    } vec_t;

    vec_t vq[$];
    int   tests  = 0;
    int   errors = 0;

    function automatic logic [4:0] outs();
        return {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
    endfunction

    task automatic push(input int tid, input logic r, input logic b,
                        input logic [4:0] e, input int n);
        vec_t v;
        v.tid   = tid;
        v.rst_n = r;
        v.btn   = b;
        v.exp   = e;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    task automatic run_table();
        logic [4:0] got;
        foreach (vq[i]) begin
            rst_n   = vq[i].rst_n;
            btn_lvl = vq[i].btn;
            @(posedge clk);
            #1;
            got = outs();
            tests++;
            if (got !== vq[i].exp) begin
                errors++;
                $display("FAIL t%0d vec%0d: outputs {p,r,l,rp,h}=%b required %b",
                         vq[i].tid, i, got, vq[i].exp);
            end
        end
        vq.delete();
    endtask

    initial begin
        logic [4:0] got;
        rst_n   = 1'b0;
        btn_lvl = 1'b1;

        // 1: reset with button down, then press accepted on 4th sampled 1
        push(1, 1'b0, 1'b1, E_NONE, 2);
        push(1, 1'b1, 1'b1, E_NONE, 3);
        push(1, 1'b1, 1'b1, E_PRESS, 1);
        push(1, 1'b1, 1'b1, E_HELD, 1);
        push(1, 1'b0, 1'b0, E_NONE, 1);
        // 2: short glitch rejected
        push(2, 1'b1, 1'b1, E_NONE, 3);
        push(2, 1'b1, 1'b0, E_NONE, 10);
        // 3: normal press/release, no long
        push(3, 1'b1, 1'b1, E_NONE, 3);
        push(3, 1'b1, 1'b1, E_PRESS, 1);
        push(3, 1'b1, 1'b1, E_HELD, 6);
        push(3, 1'b1, 1'b0, E_HELD, 3);
        push(3, 1'b1, 1'b0, E_REL, 1);
        push(3, 1'b1, 1'b0, E_NONE, 6);
        // 4: release bounce in HELD; hold_cnt frozen at 6, resumes after return edge
        push(4, 1'b1, 1'b1, E_NONE, 3);
        push(4, 1'b1, 1'b1, E_PRESS, 1);
        push(4, 1'b1, 1'b1, E_HELD, 6);
        push(4, 1'b1, 1'b0, E_HELD, 2);
        push(4, 1'b1, 1'b1, E_HELD, 14);
        push(4, 1'b1, 1'b1, E_LONG, 1);
        push(4, 1'b1, 1'b1, E_HELD, 2);
        push(4, 1'b1, 1'b0, E_HELD, 3);
        push(4, 1'b1, 1'b0, E_REL, 1);
        push(4, 1'b1, 1'b0, E_NONE, 2);
        // 5: 44-cycle hold: press@4, long@24, repeat@32,40
        push(5, 1'b0, 1'b0, E_NONE, 1);
        push(5, 1'b1, 1'b1, E_NONE, 3);
        push(5, 1'b1, 1'b1, E_PRESS, 1);
        push(5, 1'b1, 1'b1, E_HELD, 19);
        push(5, 1'b1, 1'b1, E_LONG, 1);
        push(5, 1'b1, 1'b1, E_HELD, 7);
        push(5, 1'b1, 1'b1, E_RPT, 1);
        push(5, 1'b1, 1'b1, E_HELD, 7);
        push(5, 1'b1, 1'b1, E_RPT, 1);
        push(5, 1'b1, 1'b1, E_HELD, 4);
        run_table();

        // 6: reset mid-HELD clears outputs without a clock edge
        rst_n = 1'b0;
        #2;
        got = outs();
        tests++;
        if (got !== E_NONE) begin
            errors++;
            $display("FAIL t6_async_reset: outputs %b required %b", got, E_NONE);
        end

        push(6, 1'b0, 1'b1, E_NONE, 1);
        push(6, 1'b1, 1'b0, E_NONE, 6);
        // button still down through reset: fresh press after 4 samples
        push(6, 1'b0, 1'b1, E_NONE, 1);
        push(6, 1'b1, 1'b1, E_NONE, 3);
        push(6, 1'b1, 1'b1, E_PRESS, 1);
        push(6, 1'b1, 1'b1, E_HELD, 2);
        run_table();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
